// File: rtl/fc_layer_seq.sv
// Sequential fully-connected layer: N_OUT parallel MACs step serially over N_IN inputs,
// then bias, shift, optional ReLU and saturation feed a valid/ready output register.
module fc_layer_seq #(
  parameter int unsigned N_IN     = 4,
  parameter int unsigned N_OUT    = 2,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned WEIGHT_W = 8,
  parameter int unsigned ACC_W    = 32,
  parameter int unsigned SHIFT    = 0,
  parameter int unsigned RELU_EN  = 0
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [N_IN*DATA_W-1:0]                  in_vec,
  input  logic                                    wr_en,
  input  logic [$clog2(N_OUT*N_IN+N_OUT)-1:0]     wr_addr,
  input  logic [DATA_W-1:0]                       wr_data,
  output logic                                    wr_err,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [N_OUT*DATA_W-1:0]                 out_vec,
  output logic                                    busy
);

  localparam int unsigned NumLoc = N_OUT * N_IN + N_OUT;
  localparam int unsigned AddrW  = $clog2(NumLoc);
  localparam int unsigned ProdW  = DATA_W + WEIGHT_W;
  localparam int unsigned IdxW   = (N_IN > 1) ? $clog2(N_IN) : 1;

  localparam logic signed [ACC_W-1:0] SatMax = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SatMin = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StMac  = 2'd1;
  localparam logic [1:0] StFin  = 2'd2;
  localparam logic [1:0] StOut  = 2'd3;

  logic [1:0]                 state_q, state_d;
  logic [N_IN*DATA_W-1:0]     in_q;
  logic [IdxW-1:0]            idx_q;
  logic signed [ACC_W-1:0]    acc_q [N_OUT];
  logic signed [WEIGHT_W-1:0] w_q [N_OUT][N_IN];
  logic signed [DATA_W-1:0]   b_q [N_OUT];
  logic [N_OUT*DATA_W-1:0]    out_q;
  logic                       out_valid_q;
  logic                       wr_err_q;

  // A write landing on the accepting edge is parked here so the vector in flight
  // keeps computing with the old coefficients.
  logic                       pend_q;
  logic [AddrW-1:0]           pend_addr_q;
  logic [DATA_W-1:0]          pend_data_q;

  logic                       accept, in_range, wr_ok;
  logic                       apply_en;
  logic [AddrW-1:0]           apply_addr;
  logic [DATA_W-1:0]          apply_data;

  logic signed [DATA_W-1:0]   x_cur;
  logic signed [ProdW-1:0]    prod  [N_OUT];
  logic signed [ACC_W-1:0]    sum_c [N_OUT];
  logic signed [ACC_W-1:0]    shr_c [N_OUT];
  logic [DATA_W-1:0]          res_c [N_OUT];

  assign accept    = (state_q == StIdle) && in_valid;
  assign in_range  = 32'(wr_addr) < NumLoc;
  assign wr_ok     = wr_en && (state_q == StIdle) && in_range;

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign out_valid = out_valid_q;
  assign out_vec   = out_q;
  assign wr_err    = wr_err_q;

  always_comb begin
    apply_en   = 1'b0;
    apply_addr = wr_addr;
    apply_data = wr_data;
    if (wr_ok && !accept) begin
      apply_en = 1'b1;
    end else if ((state_q == StFin) && pend_q) begin
      apply_en   = 1'b1;
      apply_addr = pend_addr_q;
      apply_data = pend_data_q;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (accept) state_d = StMac;
      StMac:   if (idx_q == IdxW'(N_IN - 1)) state_d = StFin;
      StFin:   state_d = StOut;
      StOut:   if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    x_cur = in_q[int'(idx_q)*DATA_W +: DATA_W];
    for (int o = 0; o < N_OUT; o++) begin
      prod[o]  = $signed({{WEIGHT_W{x_cur[DATA_W-1]}}, x_cur}) *
                 $signed({{DATA_W{w_q[o][idx_q][WEIGHT_W-1]}}, w_q[o][idx_q]});
      sum_c[o] = acc_q[o] + $signed({{(ACC_W-DATA_W){b_q[o][DATA_W-1]}}, b_q[o]});
      shr_c[o] = sum_c[o] >>> SHIFT;
      if ((RELU_EN != 0) && shr_c[o][ACC_W-1]) shr_c[o] = '0;
      if (shr_c[o] > SatMax)      res_c[o] = SatMax[DATA_W-1:0];
      else if (shr_c[o] < SatMin) res_c[o] = SatMin[DATA_W-1:0];
      else                        res_c[o] = shr_c[o][DATA_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      in_q        <= '0;
      idx_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      wr_err_q    <= 1'b0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
      for (int o = 0; o < N_OUT; o++) acc_q[o] <= '0;
    end else begin
      state_q  <= state_d;
      wr_err_q <= wr_en && !wr_ok;
      if (accept) begin
        in_q  <= in_vec;
        idx_q <= '0;
        for (int o = 0; o < N_OUT; o++) acc_q[o] <= '0;
      end
      if (accept && wr_ok) begin
        pend_q      <= 1'b1;
        pend_addr_q <= wr_addr;
        pend_data_q <= wr_data;
      end
      if (state_q == StMac) begin
        idx_q <= idx_q + IdxW'(1);
        for (int o = 0; o < N_OUT; o++) begin
          acc_q[o] <= acc_q[o] + $signed({{(ACC_W-ProdW){prod[o][ProdW-1]}}, prod[o]});
        end
      end
      if (state_q == StFin) begin
        pend_q      <= 1'b0;
        out_valid_q <= 1'b1;
        for (int o = 0; o < N_OUT; o++) out_q[o*DATA_W +: DATA_W] <= res_c[o];
      end
      if ((state_q == StOut) && out_ready) out_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int o = 0; o < N_OUT; o++) begin
        b_q[o] <= '0;
        for (int i = 0; i < N_IN; i++) w_q[o][i] <= '0;
      end
    end else if (apply_en) begin
      for (int o = 0; o < N_OUT; o++) begin
        for (int i = 0; i < N_IN; i++) begin
          if (apply_addr == AddrW'(o * N_IN + i)) w_q[o][i] <= apply_data[WEIGHT_W-1:0];
        end
        if (apply_addr == AddrW'(N_OUT * N_IN + o)) b_q[o] <= apply_data;
      end
    end
  end

endmodule

// File: tb/tb_fc_layer_seq.sv
// Bench for fc_layer_seq: three instances (plain, ReLU, shift-by-1) share stimulus and are
// checked every cycle against a transaction-level arithmetic model, plus literal spot checks.
module tb_fc_layer_seq;

  localparam int N_IN     = 4;
  localparam int N_OUT    = 2;
  localparam int DATA_W   = 16;
  localparam int WEIGHT_W = 8;
  localparam int ACC_W    = 32;
  localparam int NLOC     = N_OUT * N_IN + N_OUT;
  localparam int AW       = 4;
  localparam int NCFG     = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic in_valid = 1'b0;
  logic wr_en = 1'b0;
  logic out_ready = 1'b1;
  logic [N_IN*DATA_W-1:0] in_vec = '0;
  logic [AW-1:0]          wr_addr = '0;
  logic [DATA_W-1:0]      wr_data = '0;

  logic                    in_ready_a  [NCFG];
  logic                    wr_err_a    [NCFG];
  logic                    out_valid_a [NCFG];
  logic                    busy_a      [NCFG];
  logic [N_OUT*DATA_W-1:0] out_vec_a   [NCFG];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  fc_layer_seq #(.N_IN(N_IN), .N_OUT(N_OUT), .DATA_W(DATA_W), .WEIGHT_W(WEIGHT_W),
                 .ACC_W(ACC_W), .SHIFT(0), .RELU_EN(0)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a[0]), .in_vec(in_vec),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(wr_err_a[0]),
    .out_valid(out_valid_a[0]), .out_ready(out_ready), .out_vec(out_vec_a[0]), .busy(busy_a[0]));

  fc_layer_seq #(.N_IN(N_IN), .N_OUT(N_OUT), .DATA_W(DATA_W), .WEIGHT_W(WEIGHT_W),
                 .ACC_W(ACC_W), .SHIFT(0), .RELU_EN(1)) u_relu (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a[1]), .in_vec(in_vec),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(wr_err_a[1]),
    .out_valid(out_valid_a[1]), .out_ready(out_ready), .out_vec(out_vec_a[1]), .busy(busy_a[1]));

  fc_layer_seq #(.N_IN(N_IN), .N_OUT(N_OUT), .DATA_W(DATA_W), .WEIGHT_W(WEIGHT_W),
                 .ACC_W(ACC_W), .SHIFT(1), .RELU_EN(0)) u_shr (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a[2]), .in_vec(in_vec),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(wr_err_a[2]),
    .out_valid(out_valid_a[2]), .out_ready(out_ready), .out_vec(out_vec_a[2]), .busy(busy_a[2]));

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int fld(input logic [N_OUT*DATA_W-1:0] v, input int o);
    logic signed [DATA_W-1:0] t;
    t = v[o*DATA_W +: DATA_W];
    return int'(t);
  endfunction

  // ---------------- model ----------------
  int mw [N_OUT][N_IN];
  int mb [N_OUT];
  bit m_busy = 1'b0;
  bit m_valid = 1'b0;
  bit m_err = 1'b0;
  int m_left = 0;
  int m_out [NCFG][N_OUT];
  int p_exp [NCFG][N_OUT];

  function automatic int neuron(input int o, input int xs[N_IN], input int shift, input bit relu);
    longint s;
    s = longint'(mb[o]);
    for (int i = 0; i < N_IN; i++) s += longint'(xs[i]) * longint'(mw[o][i]);
    s = s >>> shift;
    if (relu && s < 0) s = 0;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return int'(s);
  endfunction

  task automatic model_step();
    int xs [N_IN];
    logic signed [DATA_W-1:0] t;
    bit idle;
    bit wr_ok;
    int a;
    if (!reset) begin
      m_busy = 0; m_valid = 0; m_err = 0; m_left = 0;
      for (int o = 0; o < N_OUT; o++) begin
        mb[o] = 0;
        for (int i = 0; i < N_IN; i++) mw[o][i] = 0;
        for (int c = 0; c < NCFG; c++) m_out[c][o] = 0;
      end
      return;
    end
    a = int'(wr_addr);
    idle = !m_busy;
    wr_ok = wr_en && idle && (a < NLOC);
    m_err = wr_en && !wr_ok;
    if (idle) begin
      if (in_valid) begin
        for (int i = 0; i < N_IN; i++) begin
          t = in_vec[i*DATA_W +: DATA_W];
          xs[i] = int'(t);
        end
        for (int c = 0; c < NCFG; c++)
          for (int o = 0; o < N_OUT; o++)
            p_exp[c][o] = neuron(o, xs, (c == 2) ? 1 : 0, c == 1);
        m_busy = 1;
        m_left = N_IN + 1;
      end
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_valid = 1;
        m_out = p_exp;
      end
    end else if (m_valid && out_ready) begin
      m_valid = 0;
      m_busy = 0;
    end
    // Coefficient update lands after the snapshot above, so a same-edge vector sees old values.
    if (wr_ok) begin
      if (a < N_OUT * N_IN) mw[a / N_IN][a % N_IN] = int'($signed(wr_data[WEIGHT_W-1:0]));
      else mb[a - N_OUT * N_IN] = int'($signed(wr_data));
    end
  endtask

  initial forever begin
    @(posedge clk or negedge reset);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    for (int c = 0; c < NCFG; c++) begin
      chk($sformatf("in_ready[%0d]", c), longint'(in_ready_a[c]), longint'(!m_busy));
      chk($sformatf("busy[%0d]", c), longint'(busy_a[c]), longint'(m_busy));
      chk($sformatf("out_valid[%0d]", c), longint'(out_valid_a[c]), longint'(m_valid));
      chk($sformatf("wr_err[%0d]", c), longint'(wr_err_a[c]), longint'(m_err));
      for (int o = 0; o < N_OUT; o++)
        chk($sformatf("out_vec[%0d][%0d]", c, o), fld(out_vec_a[c], o), m_out[c][o]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input int a, input int d);
    wr_en = 1'b1;
    wr_addr = AW'(a);
    wr_data = DATA_W'(d);
    step();
    wr_en = 1'b0;
  endtask

  task automatic set_vec(input int a, input int b, input int c, input int d);
    in_vec = {DATA_W'(d), DATA_W'(c), DATA_W'(b), DATA_W'(a)};
  endtask

  task automatic accept();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid_a[0] && n < 20) begin
      step();
      n++;
    end
    if (!out_valid_a[0]) begin
      total++;
      bad++;
      $display("FAIL wait_out_valid: got 0 after %0d cycles, expected 1", n);
    end
  endtask

  task automatic prog_basic();
    wr(0, 2);  wr(1, -1); wr(2, 3); wr(3, 1);
    wr(4, -2); wr(5, 2);  wr(6, 1); wr(7, -3);
    wr(8, 0);  wr(9, 5);
  endtask

  task automatic chk_out(input string name, input int c, input int e0, input int e1);
    chk({name, "_n0"}, fld(out_vec_a[c], 0), e0);
    chk({name, "_n1"}, fld(out_vec_a[c], 1), e1);
  endtask

  initial begin
    int n;
    step();
    step();
    chk("rst_in_ready", in_ready_a[0], 1);
    chk("rst_busy", busy_a[0], 0);
    chk("rst_out_valid", out_valid_a[0], 0);
    chk("rst_out_vec", out_vec_a[0], 0);
    reset = 1'b1;
    step();

    prog_basic();
    set_vec(1, 2, 3, 4);
    accept();
    wait_valid(n);
    chk("latency", n, 5);
    chk_out("basic", 0, 13, -2);
    chk_out("relu", 1, 13, 0);
    chk_out("shift", 2, 6, -1);
    step();

    set_vec(-3, 5, 0, 7);
    accept();
    wait_valid(n);
    chk_out("vec2", 0, -4, 0);
    step();

    // Backpressure, with in_valid asserted throughout and at the release edge.
    out_ready = 1'b0;
    set_vec(1, 2, 3, 4);
    accept();
    wait_valid(n);
    in_valid = 1'b1;
    set_vec(9, 9, 9, 9);
    repeat (6) step();
    chk_out("hold", 0, 13, -2);
    chk("hold_in_ready", in_ready_a[0], 0);
    out_ready = 1'b1;
    step();
    chk("release_in_ready", in_ready_a[0], 1);
    chk("release_out_valid", out_valid_a[0], 0);
    step();
    in_valid = 1'b0;
    wait_valid(n);
    chk_out("nines", 0, 45, -13);
    step();

    set_vec(1, 2, 3, 4);
    accept();
    wr(0, 100);
    chk("wr_err_mac", wr_err_a[0], 1);
    wait_valid(n);
    chk_out("after_mac_wr", 0, 13, -2);
    step();

    wr(NLOC, 7);
    chk("wr_err_range", wr_err_a[0], 1);

    wr_en = 1'b1; wr_addr = AW'(0); wr_data = DATA_W'(5);
    in_valid = 1'b1;
    step();
    wr_en = 1'b0; in_valid = 1'b0;
    wait_valid(n);
    chk_out("same_edge_old", 0, 13, -2);
    step();
    accept();
    wait_valid(n);
    chk_out("same_edge_new", 0, 16, -2);
    step();

    for (int a = 0; a < N_OUT * N_IN; a++) wr(a, 127);
    wr(8, 0);
    wr(9, 0);
    set_vec(32767, 32767, 32767, 32767);
    accept();
    wait_valid(n);
    chk_out("sat_pos", 0, 32767, 32767);
    step();
    set_vec(-32768, -32768, -32768, -32768);
    accept();
    wait_valid(n);
    chk_out("sat_neg", 0, -32768, -32768);
    chk_out("sat_neg_relu", 1, 0, 0);
    step();

    prog_basic();
    set_vec(1, 2, 3, 4);
    accept();
    step();
    reset = 1'b0;
    step();
    chk("midrst_out_valid", out_valid_a[0], 0);
    chk("midrst_in_ready", in_ready_a[0], 1);
    reset = 1'b1;
    step();
    accept();
    wait_valid(n);
    chk_out("rerun_cleared", 0, 0, 0);
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
